seq_magnitude_comparator: RTL

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/seq_magnitude_comparator.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: walks the latched operands one CHUNK-bit
// slice per cycle from the top, stopping at the first differing slice.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CHUNK-1:0]   slice_a, slice_b;

  assign slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit of both operands maps two's-complement
          // order onto unsigned order, so every slice compares unsigned.
          a_d     = a ^ (signed_mode ? MSB_MASK : '0);
          b_d     = b ^ (signed_mode ? MSB_MASK : '0);
          idx_d   = IDX_W'(N - 1);
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (slice_a != slice_b) begin
          gt_d    = (slice_a > slice_b);
          lt_d    = (slice_a < slice_b);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy   = (state_q == COMPARE);
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;

endmodule
